// File: rtl/ariane_pkg.sv
// Shared frontend constants and the compressed-instruction test used by the
// realigner and the compressed decoder.
package ariane_pkg;

    localparam int unsigned FETCH_WIDTH     = 64;
    localparam int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_realign.sv
// Splits a fetch block into packed 16/32-bit instructions and carries the lower
// half of a 32-bit instruction that straddles into the next fetch block.
module instr_realign
    import ariane_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH     = ariane_pkg::FETCH_WIDTH,
    parameter int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       replay_i,
    input  logic                       valid_i,
    input  logic [63:0]                address_i,
    input  logic [FETCH_WIDTH-1:0]     data_i,
    output logic                       serving_unaligned_o,
    output logic [INSTR_PER_FETCH-1:0] valid_o,
    output logic [31:0]                instr_o [INSTR_PER_FETCH],
    output logic [63:0]                addr_o  [INSTR_PER_FETCH]
);

    localparam int unsigned OFF_W = $clog2(FETCH_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(INSTR_PER_FETCH);

    logic        unaligned_q;
    logic [15:0] unaligned_instr_q;
    logic [63:0] unaligned_address_q;

    logic        open_d;
    logic [15:0] open_instr_d;
    logic [63:0] open_addr_d;

    logic [63:0]      base;
    logic [IDX_W-1:0] start_hw;
    logic [IDX_W-1:0] slot;
    int               next_hw;

    // One spare zero halfword so the upper-half read at the last position stays in range.
    logic [15:0] hw [INSTR_PER_FETCH+1];

    assign base     = address_i & ~((64'd1 << OFF_W) - 64'd1);
    assign start_hw = address_i[OFF_W-1:1];

    always_comb begin
        for (int h = 0; h < int'(INSTR_PER_FETCH); h++) begin
            hw[h] = data_i[16*h +: 16];
        end
        hw[INSTR_PER_FETCH] = '0;
    end

    // NOTE: blocking assignments here on purpose; slot and next_hw are running
    // variables of the unrolled scan, and every output gets a default first so
    // no latch is inferred.
    always_comb begin
        valid_o      = '0;
        open_d       = 1'b0;
        open_instr_d = '0;
        open_addr_d  = '0;
        slot         = '0;
        next_hw      = 0;
        for (int j = 0; j < int'(INSTR_PER_FETCH); j++) begin
            instr_o[j] = '0;
            addr_o[j]  = '0;
        end

        if (valid_i) begin
            next_hw = int'(start_hw);
            // A saved half only continues into a sequential block starting at halfword 0.
            if (unaligned_q && start_hw == '0) begin
                valid_o[0] = 1'b1;
                instr_o[0] = {hw[0], unaligned_instr_q};
                addr_o[0]  = unaligned_address_q;
                slot       = IDX_W'(1);
                next_hw    = 1;
            end
            for (int h = 0; h < int'(INSTR_PER_FETCH); h++) begin
                if (h == next_hw) begin
                    if (is_compressed(hw[h])) begin
                        valid_o[slot] = 1'b1;
                        instr_o[slot] = {16'h0, hw[h]};
                        addr_o[slot]  = base + 64'(2 * h);
                        slot          = slot + IDX_W'(1);
                        next_hw       = h + 1;
                    end else if (h < int'(INSTR_PER_FETCH) - 1) begin
                        valid_o[slot] = 1'b1;
                        instr_o[slot] = {hw[h+1], hw[h]};
                        addr_o[slot]  = base + 64'(2 * h);
                        slot          = slot + IDX_W'(1);
                        next_hw       = h + 2;
                    end else begin
                        open_d       = 1'b1;
                        open_instr_d = hw[h];
                        open_addr_d  = base + 64'(2 * h);
                    end
                end
            end
        end
    end

    // NOTE: the saved-half registers are few, so all of them take the async reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unaligned_q         <= 1'b0;
            unaligned_instr_q   <= '0;
            unaligned_address_q <= '0;
        end else if (flush_i) begin
            unaligned_q <= 1'b0;
        end else if (replay_i) begin
            unaligned_q         <= 1'b0;
            unaligned_instr_q   <= '0;
            unaligned_address_q <= '0;
        end else if (valid_i) begin
            unaligned_q <= open_d;
            if (open_d) begin
                unaligned_instr_q   <= open_instr_d;
                unaligned_address_q <= open_addr_d;
            end
        end
    end

    assign serving_unaligned_o = unaligned_q;

endmodule

// File: tb/tb_instr_realign.sv
// Directed bench for instr_realign: a sequential vector table plus a mid-cycle
// asynchronous reset sequence.
module tb_instr_realign;

    localparam int N = 4;
    localparam logic [63:0] B = 64'h0000_0000_8000_0000;
    localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] C = 64'h0000_0000_9000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, replay_i, valid_i;
    logic [63:0] address_i;
    logic [63:0] data_i;
    logic        serving_unaligned_o;
    logic [N-1:0] valid_o;
    logic [31:0] instr_o [N];
    logic [63:0] addr_o  [N];

    instr_realign dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .replay_i            (replay_i),
        .valid_i             (valid_i),
        .address_i           (address_i),
        .data_i              (data_i),
        .serving_unaligned_o (serving_unaligned_o),
        .valid_o             (valid_o),
        .instr_o             (instr_o),
        .addr_o              (addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush, replay, valid;
        logic [63:0] addr, data;
        logic        chk;      // 0: outputs don't-care, check serving only
        logic [3:0]  ev;
        logic        serving;
        logic [31:0] ins [N];
        logic [63:0] ad  [N];
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic fl, rp, vl, input logic [63:0] a, d,
                                input logic ck, input logic [3:0] ev, input logic sv,
                                input logic [31:0] i0, i1, i2, i3,
                                input logic [63:0] a0, a1, a2, a3);
        vec_t v;
        v.flush = fl; v.replay = rp; v.valid = vl; v.addr = a; v.data = d;
        v.chk = ck; v.ev = ev; v.serving = sv;
        v.ins[0] = i0; v.ins[1] = i1; v.ins[2] = i2; v.ins[3] = i3;
        v.ad[0] = a0; v.ad[1] = a1; v.ad[2] = a2; v.ad[3] = a3;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 0; replay_i = 0; valid_i = 0; address_i = '0; data_i = '0;

        vq.push_back(mk(0,0,0, 64'h0, 64'h0, 1,4'b0000,0, 0,0,0,0, 0,0,0,0));
        vq.push_back(mk(0,0,1, B, 64'h0001_0001_0001_0001, 1,4'b1111,0, 1,1,1,1, B,B+2,B+4,B+6));
        vq.push_back(mk(0,0,1, B, 64'h0297_4501_0000_0013, 1,4'b0011,0, 32'h13,32'h4501,0,0, B,B+4,0,0));
        vq.push_back(mk(0,0,1, B+8, 64'h0001_0001_0001_0000, 1,4'b1111,1, 32'h297,1,1,1, B+6,B+10,B+12,B+14));
        vq.push_back(mk(0,0,1, B+6, 64'h0001_0000_0000_0000, 1,4'b0001,0, 1,0,0,0, B+6,0,0,0));
        vq.push_back(mk(0,0,1, B+6, 64'h0297_0000_0000_0000, 1,4'b0000,0, 0,0,0,0, 0,0,0,0));
        vq.push_back(mk(0,0,0, 64'h0, 64'h0, 1,4'b0000,1, 0,0,0,0, 0,0,0,0));
        vq.push_back(mk(1,0,0, 64'h0, 64'h0, 0,4'b0000,1, 0,0,0,0, 0,0,0,0));
        vq.push_back(mk(0,0,1, C, 64'h0001_0001_0001_0001, 1,4'b1111,0, 1,1,1,1, C,C+2,C+4,C+6));
        vq.push_back(mk(0,0,1, B, 64'h0297_0001_0001_0001, 1,4'b0111,0, 1,1,1,0, B,B+2,B+4,0));
        vq.push_back(mk(0,0,1, B+18, 64'h0001_0001_0001_FFFF, 1,4'b0111,1, 1,1,1,0, B+18,B+20,B+22,0));
        vq.push_back(mk(0,0,0, 64'h0, 64'h0, 1,4'b0000,0, 0,0,0,0, 0,0,0,0));
        vq.push_back(mk(0,1,1, B, 64'h0297_0001_0001_0001, 1,4'b0111,0, 1,1,1,0, B,B+2,B+4,0));
        vq.push_back(mk(0,0,0, 64'h0, 64'h0, 1,4'b0000,0, 0,0,0,0, 0,0,0,0));
        vq.push_back(mk(0,0,1, B, 64'h8082_ABCD_02B7_0001, 1,4'b0111,0, 1,32'hABCD_02B7,32'h8082,0, B,B+2,B+6,0));
        vq.push_back(mk(0,0,1, W, 64'h0297_0001_0001_0001, 1,4'b0111,0, 1,1,1,0, W,W+2,W+4,0));
        vq.push_back(mk(0,0,1, 64'h0, 64'h0001_0001_0001_0000, 1,4'b1111,1, 32'h297,1,1,1, W+6,64'h2,64'h4,64'h6));
        vq.push_back(mk(0,0,1, B, 64'h0297_0001_0001_0001, 1,4'b0111,0, 1,1,1,0, B,B+2,B+4,0));
        vq.push_back(mk(0,1,0, 64'h0, 64'h0, 0,4'b0000,1, 0,0,0,0, 0,0,0,0));
        vq.push_back(mk(0,0,0, 64'h0, 64'h0, 1,4'b0000,0, 0,0,0,0, 0,0,0,0));

        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk_i);
            flush_i = vq[i].flush; replay_i = vq[i].replay; valid_i = vq[i].valid;
            address_i = vq[i].addr; data_i = vq[i].data;
            #1;
            check($sformatf("v%0d serving", i), 64'(serving_unaligned_o), 64'(vq[i].serving));
            if (vq[i].chk) begin
                check($sformatf("v%0d valid_o", i), 64'(valid_o), 64'(vq[i].ev));
                for (int j = 0; j < N; j++) begin
                    if (vq[i].ev[j] || !vq[i].valid) begin
                        check($sformatf("v%0d instr%0d", i, j), 64'(instr_o[j]), 64'(vq[i].ins[j]));
                        check($sformatf("v%0d addr%0d", i, j), addr_o[j], vq[i].ad[j]);
                    end
                end
            end
        end

        // Open half pending, then async reset between clock edges.
        @(negedge clk_i);
        flush_i = 0; replay_i = 0; valid_i = 1;
        address_i = B; data_i = 64'h0297_0001_0001_0001;
        @(negedge clk_i);
        valid_i = 0; address_i = '0; data_i = '0;
        #1;
        check("pre-reset serving", 64'(serving_unaligned_o), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        check("async reset serving", 64'(serving_unaligned_o), 64'd0);
        check("async reset valid_o", 64'(valid_o), 64'd0);
        check("async reset addr0", addr_o[0], 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        valid_i = 1; address_i = B + 8; data_i = 64'h0001_0001_0001_0001;
        #1;
        check("post-reset serving", 64'(serving_unaligned_o), 64'd0);
        check("post-reset addr0", addr_o[0], B + 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
